seq_alu: RTL and testbench

- Parametrised, handshaked successor to the single-cycle ALU for the pipelined and multi-cycle miniRV cores.
- Executes the RV32I integer ops in one registered cycle.
- Adds RV32M multiply/divide/remainder, executed iteratively over XLEN cycles.
- Produces a branch flag with correct signed and unsigned compares.
- Sits between decode/issue and writeback; a valid/ready pair on each side lets the core stall on long ops.

---
 rtl/seq_alu_pkg.sv | 54 +++++
 rtl/seq_alu_if.sv | 24 ++
 rtl/seq_muldiv_iter.sv | 65 ++++++
 rtl/seq_alu.sv | 179 +++++++++++++++++
 tb/tb_seq_alu.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/seq_alu_pkg.sv
// Shared encodings for the sequential ALU: operation codes, branch compares and FSM states.
// Also holds small helpers that classify operations.
package seq_alu_pkg;

    typedef enum logic [4:0] {
        OP_ADD    = 5'd0,
        OP_SUB    = 5'd1,
        OP_AND    = 5'd2,
        OP_OR     = 5'd3,
        OP_XOR    = 5'd4,
        OP_SLL    = 5'd5,
        OP_SRL    = 5'd6,
        OP_SRA    = 5'd7,
        OP_SLT    = 5'd8,
        OP_SLTU   = 5'd9,
        OP_MUL    = 5'd10,
        OP_MULH   = 5'd11,
        OP_MULHSU = 5'd12,
        OP_MULHU  = 5'd13,
        OP_DIV    = 5'd14,
        OP_DIVU   = 5'd15,
        OP_REM    = 5'd16,
        OP_REMU   = 5'd17
    } alu_op_e;

    typedef enum logic [2:0] {
        BR_NONE = 3'd0,
        BR_BEQ  = 3'd1,
        BR_BNE  = 3'd2,
        BR_BLT  = 3'd3,
        BR_BGE  = 3'd4,
        BR_BLTU = 3'd5,
        BR_BGEU = 3'd6
    } br_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ITER = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    function automatic logic is_md_op(alu_op_e op);
        return (op >= OP_MUL) && (op <= OP_REMU);
    endfunction

    function automatic logic is_div_op(alu_op_e op);
        return (op >= OP_DIV) && (op <= OP_REMU);
    endfunction

    function automatic logic is_quot_op(alu_op_e op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

endpackage

// File: rtl/seq_alu_if.sv
// Issue/result handshake bundle between the issuing stage and the sequential ALU.
interface seq_alu_if #(parameter int XLEN = 32);
    logic            in_valid;
    logic            in_ready;
    logic [XLEN-1:0] A;
    logic [XLEN-1:0] B;
    logic [4:0]      alu_op;
    logic [2:0]      br_op;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] ALU_C;
    logic            ALU_F;
    logic            busy;

    modport master (
        output in_valid, A, B, alu_op, br_op, out_ready,
        input  in_ready, out_valid, ALU_C, ALU_F, busy
    );

    modport slave (
        input  in_valid, A, B, alu_op, br_op, out_ready,
        output in_ready, out_valid, ALU_C, ALU_F, busy
    );
endinterface

// File: rtl/seq_muldiv_iter.sv
// Unsigned iterative core: shift-add multiply or restoring divide, one bit per cycle.
// res_hi/res_lo show the post-step value, so they carry the final answer in the cycle done is high.
module seq_muldiv_iter #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [XLEN-1:0] a_mag,
    input  logic [XLEN-1:0] b_mag,
    input  logic            is_div,
    output logic            done,
    output logic [XLEN-1:0] res_hi,
    output logic [XLEN-1:0] res_lo
);
    localparam int CW = $clog2(XLEN);

    logic [XLEN-1:0] hi_reg, lo_reg, b_reg;
    logic            div_reg, run_reg;
    logic [CW-1:0]   cnt_reg;
    logic [XLEN:0]   sum, shifted, diff;

    // hi/lo hold {partial product, multiplier} or {remainder, dividend/quotient}
    always_comb begin
        sum     = {1'b0, hi_reg} + (lo_reg[0] ? {1'b0, b_reg} : '0);
        shifted = {hi_reg, lo_reg[XLEN-1]};
        diff    = shifted - {1'b0, b_reg};
        if (!div_reg) begin
            {res_hi, res_lo} = {sum, lo_reg[XLEN-1:1]};
        end else if (!diff[XLEN]) begin
            res_hi = diff[XLEN-1:0];
            res_lo = {lo_reg[XLEN-2:0], 1'b1};
        end else begin
            res_hi = shifted[XLEN-1:0];
            res_lo = {lo_reg[XLEN-2:0], 1'b0};
        end
    end

    assign done = run_reg && (cnt_reg == CW'(XLEN - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            hi_reg  <= '0;
            lo_reg  <= '0;
            b_reg   <= '0;
            div_reg <= 1'b0;
            run_reg <= 1'b0;
            cnt_reg <= '0;
        end else if (start) begin
            hi_reg  <= '0;
            lo_reg  <= a_mag;
            b_reg   <= b_mag;
            div_reg <= is_div;
            run_reg <= 1'b1;
            cnt_reg <= '0;
        end else if (run_reg) begin
            hi_reg  <= res_hi;
            lo_reg  <= res_lo;
            cnt_reg <= cnt_reg + 1'b1;
            if (done) begin
                run_reg <= 1'b0;
            end
        end
    end
endmodule

// File: rtl/seq_alu.sv
// Handshaked RV32I/M ALU: base ops in one registered cycle, M ops iterated over XLEN cycles.
// Signs are stripped before the unsigned core and restored when it finishes.
module seq_alu
    import seq_alu_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter bit MD_EN = 1'b1
) (
    input logic       clk,
    input logic       rst,
    seq_alu_if.slave  bus
);
    localparam int SW = $clog2(XLEN);
    localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

    state_e          state_reg, state_next;
    alu_op_e         op_reg, op_next, op;
    br_op_e          br;
    logic [XLEN-1:0] res_reg, res_next;
    logic            flag_reg, flag_next;
    logic            sa_reg, sa_next, sb_reg, sb_next;
    logic            accept, start, core_done, md_op, div_special, br_flag, sa, sb;
    logic [XLEN-1:0] core_hi, core_lo, a_mag, b_mag, diff;
    logic [XLEN-1:0] single_res, special_res, fix_res;
    logic [2*XLEN-1:0] prod_fix;

    assign op   = alu_op_e'(bus.alu_op);
    assign br   = br_op_e'(bus.br_op);
    assign diff = bus.A - bus.B;

    assign bus.in_ready  = (state_reg == ST_IDLE) || (state_reg == ST_DONE && bus.out_ready);
    assign bus.out_valid = (state_reg == ST_DONE);
    assign bus.busy      = (state_reg == ST_ITER);
    assign bus.ALU_C     = res_reg;
    assign bus.ALU_F     = flag_reg;
    assign accept        = bus.in_valid && bus.in_ready;

    always_comb begin
        case (br)
            BR_BEQ:  br_flag = (bus.A == bus.B);
            BR_BNE:  br_flag = (bus.A != bus.B);
            BR_BLT:  br_flag = ($signed(bus.A) <  $signed(bus.B));
            BR_BGE:  br_flag = ($signed(bus.A) >= $signed(bus.B));
            BR_BLTU: br_flag = (bus.A <  bus.B);
            BR_BGEU: br_flag = (bus.A >= bus.B);
            default: br_flag = 1'b0;
        endcase
    end

    always_comb begin
        case (op)
            OP_ADD:  single_res = bus.A + bus.B;
            OP_SUB:  single_res = diff;
            OP_AND:  single_res = bus.A & bus.B;
            OP_OR:   single_res = bus.A | bus.B;
            OP_XOR:  single_res = bus.A ^ bus.B;
            OP_SLL:  single_res = bus.A << bus.B[SW-1:0];
            OP_SRL:  single_res = bus.A >> bus.B[SW-1:0];
            OP_SRA:  single_res = $unsigned($signed(bus.A) >>> bus.B[SW-1:0]);
            OP_SLT:  single_res = {{(XLEN-1){1'b0}}, $signed(bus.A) < $signed(bus.B)};
            OP_SLTU: single_res = {{(XLEN-1){1'b0}}, bus.A < bus.B};
            default: single_res = '0;
        endcase
    end

    // Operand signs that the core must see as magnitudes
    always_comb begin
        sa = 1'b0;
        sb = 1'b0;
        case (op)
            OP_MUL, OP_MULH, OP_DIV, OP_REM: begin
                sa = bus.A[XLEN-1];
                sb = bus.B[XLEN-1];
            end
            OP_MULHSU: sa = bus.A[XLEN-1];
            default: ;
        endcase
    end

    assign a_mag = sa ? -bus.A : bus.A;
    assign b_mag = sb ? -bus.B : bus.B;
    assign md_op = MD_EN && is_md_op(op);
    assign div_special = is_div_op(op) && ((bus.B == '0) ||
                         ((op == OP_DIV || op == OP_REM) && bus.A == MOST_NEG && bus.B == '1));

    always_comb begin
        if (bus.B == '0) begin
            special_res = is_quot_op(op) ? '1 : bus.A;
        end else begin
            special_res = is_quot_op(op) ? bus.A : '0;
        end
    end

    assign prod_fix = (sa_reg ^ sb_reg) ? -{core_hi, core_lo} : {core_hi, core_lo};

    always_comb begin
        case (op_reg)
            OP_MUL:                       fix_res = prod_fix[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: fix_res = prod_fix[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:              fix_res = (sa_reg ^ sb_reg) ? -core_lo : core_lo;
            OP_REM, OP_REMU:              fix_res = sa_reg ? -core_hi : core_hi;
            default:                      fix_res = '0;
        endcase
    end

    always_comb begin
        state_next = state_reg;
        res_next   = res_reg;
        flag_next  = flag_reg;
        op_next    = op_reg;
        sa_next    = sa_reg;
        sb_next    = sb_reg;
        start      = 1'b0;
        case (state_reg)
            ST_IDLE, ST_DONE: begin
                if (accept) begin
                    flag_next = br_flag;
                    if (md_op && !div_special) begin
                        start      = 1'b1;
                        op_next    = op;
                        sa_next    = sa;
                        sb_next    = sb;
                        state_next = ST_ITER;
                    end else begin
                        res_next   = (md_op && div_special) ? special_res : single_res;
                        state_next = ST_DONE;
                    end
                end else if (state_reg == ST_DONE && bus.out_ready) begin
                    state_next = ST_IDLE;
                end
            end
            ST_ITER: begin
                if (core_done) begin
                    res_next   = fix_res;
                    state_next = ST_DONE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
            res_reg   <= '0;
            flag_reg  <= 1'b0;
            op_reg    <= OP_ADD;
            sa_reg    <= 1'b0;
            sb_reg    <= 1'b0;
        end else begin
            state_reg <= state_next;
            res_reg   <= res_next;
            flag_reg  <= flag_next;
            op_reg    <= op_next;
            sa_reg    <= sa_next;
            sb_reg    <= sb_next;
        end
    end

    generate
        if (MD_EN) begin : g_md
            seq_muldiv_iter #(.XLEN(XLEN)) u_iter (
                .clk    (clk),
                .rst    (rst),
                .start  (start),
                .a_mag  (a_mag),
                .b_mag  (b_mag),
                .is_div (is_div_op(op)),
                .done   (core_done),
                .res_hi (core_hi),
                .res_lo (core_lo)
            );
        end else begin : g_no_md
            assign core_done = 1'b0;
            assign core_hi   = '0;
            assign core_lo   = '0;
        end
    endgenerate
endmodule

// File: tb/tb_seq_alu.sv
// Bench for seq_alu: vector table through a latency-stamped scoreboard, plus stall/reset/busy sequences.
module tb_seq_alu;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    seq_alu_if #(.XLEN(32)) bus ();

    seq_alu #(.XLEN(32), .MD_EN(1'b1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [4:0]  op;
        logic [2:0]  br;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] c;
        logic        f;
        int          lat;
    } vec_t;

    typedef struct {
        logic [31:0] c;
        logic        f;
        int          lat;
        int          acc;
    } sb_t;

    sb_t  exp_q[$];
    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, want, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: bound expired (cycle %0d)", name, cyc);
    endtask

    function automatic vec_t mk(input logic [4:0] op, input logic [2:0] br, input logic [31:0] a,
                                input logic [31:0] b, input logic [31:0] c, input logic f, input int lat);
        vec_t v;
        v.op = op; v.br = br; v.a = a; v.b = b; v.c = c; v.f = f; v.lat = lat;
        return v;
    endfunction

    // lat == 0 means the result may legitimately be held back by the consumer
    always @(negedge clk) begin
        if (!rst && bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
                fail_now("unexpected_result");
            end else begin
                sb_t e;
                e = exp_q.pop_front();
                check("result_c", bus.ALU_C, e.c);
                check("result_f", {31'b0, bus.ALU_F}, {31'b0, e.f});
                if (e.lat != 0) check("latency", cyc - e.acc, e.lat);
                $display("[TB] out C=%h F=%0d latency=%0d", bus.ALU_C, bus.ALU_F, cyc - e.acc);
            end
        end
    end

    task automatic issue(input vec_t v, input bit keep, output int waited);
        sb_t e;
        bus.in_valid = 1'b1;
        bus.alu_op   = v.op;
        bus.br_op    = v.br;
        bus.A        = v.a;
        bus.B        = v.b;
        waited       = 0;
        @(negedge clk);
        while (!bus.in_ready && waited < 200) begin
            waited++;
            @(negedge clk);
        end
        if (!bus.in_ready) begin
            fail_now("accept_timeout");
        end else begin
            e.c = v.c; e.f = v.f; e.lat = v.lat; e.acc = cyc;
            exp_q.push_back(e);
            $display("[TB] issue op=%0d br=%0d A=%h B=%h expect C=%h F=%0d", v.op, v.br, v.a, v.b, v.c, v.f);
        end
        @(posedge clk);
        #1;
        if (!keep) bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() > 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        if (exp_q.size() > 0) fail_now("drain_timeout");
        @(posedge clk);
        #1;
    endtask

    initial begin
        int w;
        int busy_cnt;
        int k;
        logic [31:0] held_c;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        bus.A         = '0;
        bus.B         = '0;
        bus.alu_op    = '0;
        bus.br_op     = '0;

        // Table: op br A B expC expF latency
        vecs.push_back(mk(0,  0, 32'd5,        32'd7,        32'd12,       1'b0, 1));
        vecs.push_back(mk(1,  0, 32'd3,        32'd5,        32'hFFFFFFFE, 1'b0, 1));
        vecs.push_back(mk(0,  3, 32'hFFFFFFFF, 32'd1,        32'h00000000, 1'b1, 1));
        vecs.push_back(mk(0,  5, 32'hFFFFFFFF, 32'd1,        32'h00000000, 1'b0, 1));
        vecs.push_back(mk(4,  1, 32'h1234,     32'h1234,     32'h00000000, 1'b1, 1));
        vecs.push_back(mk(4,  2, 32'h1234,     32'h1234,     32'h00000000, 1'b0, 1));
        vecs.push_back(mk(0,  4, 32'hFFFFFFFF, 32'd1,        32'h00000000, 1'b0, 1));
        vecs.push_back(mk(0,  6, 32'hFFFFFFFF, 32'd1,        32'h00000000, 1'b1, 1));
        vecs.push_back(mk(0,  7, 32'd9,        32'd9,        32'd18,       1'b0, 1));
        vecs.push_back(mk(2,  0, 32'hF0F0,     32'hFF00,     32'hF000,     1'b0, 1));
        vecs.push_back(mk(3,  0, 32'hF0F0,     32'hFF00,     32'hFFF0,     1'b0, 1));
        vecs.push_back(mk(5,  0, 32'd1,        32'd35,       32'd8,        1'b0, 1));
        vecs.push_back(mk(6,  0, 32'h80000000, 32'd4,        32'h08000000, 1'b0, 1));
        vecs.push_back(mk(7,  0, 32'h80000000, 32'd4,        32'hF8000000, 1'b0, 1));
        vecs.push_back(mk(8,  0, 32'hFFFFFFFF, 32'd1,        32'd1,        1'b0, 1));
        vecs.push_back(mk(9,  0, 32'hFFFFFFFF, 32'd1,        32'd0,        1'b0, 1));
        vecs.push_back(mk(11, 1, 32'h80000000, 32'h80000000, 32'h40000000, 1'b1, 33));
        vecs.push_back(mk(10, 0, 32'h80000000, 32'h80000000, 32'h00000000, 1'b0, 33));
        vecs.push_back(mk(10, 0, 32'd6,        32'd7,        32'd42,       1'b0, 33));
        vecs.push_back(mk(10, 0, 32'hFFFFFFFD, 32'd5,        32'hFFFFFFF1, 1'b0, 33));
        vecs.push_back(mk(12, 0, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 1'b0, 33));
        vecs.push_back(mk(13, 0, 32'hFFFFFFFF, 32'd2,        32'h00000001, 1'b0, 33));
        vecs.push_back(mk(14, 0, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 1'b0, 33));
        vecs.push_back(mk(16, 0, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 1'b0, 33));
        vecs.push_back(mk(14, 0, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 1'b0, 33));
        vecs.push_back(mk(16, 0, 32'd7,        32'hFFFFFFFE, 32'd1,        1'b0, 33));
        vecs.push_back(mk(15, 0, 32'd100,      32'd7,        32'd14,       1'b0, 33));
        vecs.push_back(mk(17, 0, 32'd100,      32'd7,        32'd2,        1'b0, 33));
        vecs.push_back(mk(15, 0, 32'd5,        32'd0,        32'hFFFFFFFF, 1'b0, 1));
        vecs.push_back(mk(17, 0, 32'd5,        32'd0,        32'd5,        1'b0, 1));
        vecs.push_back(mk(14, 0, 32'd5,        32'd0,        32'hFFFFFFFF, 1'b0, 1));
        vecs.push_back(mk(14, 0, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b0, 1));
        vecs.push_back(mk(16, 0, 32'h80000000, 32'hFFFFFFFF, 32'd0,        1'b0, 1));
        vecs.push_back(mk(31, 1, 32'd3,        32'd3,        32'd0,        1'b1, 1));

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset_out_valid", {31'b0, bus.out_valid}, 32'd0);
        check("reset_busy",      {31'b0, bus.busy},      32'd0);
        check("reset_in_ready",  {31'b0, bus.in_ready},  32'd1);
        check("reset_alu_c",     bus.ALU_C,              32'd0);
        check("reset_alu_f",     {31'b0, bus.ALU_F},     32'd0);
        @(posedge clk);
        #1;

        // Back-to-back issue: the second op must be taken the cycle after the first
        issue(vecs[0], 1'b1, w);
        issue(vecs[1], 1'b0, w);
        check("back_to_back_wait", w, 0);
        drain();

        foreach (vecs[i]) issue(vecs[i], 1'b0, w);
        drain();

        // busy must be high for exactly XLEN cycles of a multiply
        issue(mk(11, 0, 32'h80000000, 32'h80000000, 32'h40000000, 1'b0, 33), 1'b0, w);
        busy_cnt = 0;
        k = 0;
        @(negedge clk);
        while (!bus.out_valid && k < 40) begin
            if (bus.busy) busy_cnt++;
            k++;
            @(negedge clk);
        end
        check("mulh_busy_cycles", busy_cnt, 32);
        check("busy_low_at_done", {31'b0, bus.busy}, 32'd0);
        drain();

        // Consumer stall: result held, no new accept, pending op taken on release
        bus.out_ready = 1'b0;
        issue(mk(0, 2, 32'h100, 32'h23, 32'h123, 1'b1, 0), 1'b0, w);
        bus.in_valid = 1'b1;
        bus.alu_op   = 5'd1;
        bus.br_op    = 3'd0;
        bus.A        = 32'd10;
        bus.B        = 32'd3;
        held_c       = 32'h123;
        for (int s = 0; s < 5; s++) begin
            @(negedge clk);
            check("stall_out_valid", {31'b0, bus.out_valid}, 32'd1);
            check("stall_in_ready",  {31'b0, bus.in_ready},  32'd0);
            check("stall_alu_c",     bus.ALU_C,              held_c);
            check("stall_alu_f",     {31'b0, bus.ALU_F},     32'd1);
        end
        @(posedge clk);
        #1 bus.out_ready = 1'b1;
        issue(mk(1, 0, 32'd10, 32'd3, 32'd7, 1'b0, 1), 1'b0, w);
        check("release_accept_wait", w, 0);
        drain();

        // Reset during DIVU iteration 10 aborts silently
        issue(mk(15, 0, 32'd1000, 32'd3, 32'd333, 1'b0, 33), 1'b0, w);
        repeat (10) @(posedge clk);
        #1;
        check("busy_before_abort", {31'b0, bus.busy}, 32'd1);
        rst = 1'b1;
        exp_q.delete();
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("abort_out_valid", {31'b0, bus.out_valid}, 32'd0);
        check("abort_busy",      {31'b0, bus.busy},      32'd0);
        check("abort_in_ready",  {31'b0, bus.in_ready},  32'd1);
        check("abort_alu_c",     bus.ALU_C,              32'd0);
        @(posedge clk);
        #1;
        issue(mk(0, 0, 32'd1, 32'd2, 32'd3, 1'b0, 1), 1'b0, w);
        drain();
        repeat (40) @(negedge clk);
        check("no_stray_result", {31'b0, bus.out_valid}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end
endmodule
